// File: rtl/icap_reboot_ctrl_pkg.sv
// Shared definitions for the ICAP reboot controller: state encoding, the
// ICAP command words of the IPROG sequence, and the byte bit-reversal helper.
package icap_reboot_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GUARD  = 2'd1,
    ST_STREAM = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam int         WORD_COUNT    = 16;
  localparam logic [3:0] LAST_WORD_IDX = 4'(WORD_COUNT - 1);

  localparam logic [15:0] SYNC_WORD_0   = 16'hAA99;
  localparam logic [15:0] SYNC_WORD_1   = 16'h5566;
  localparam logic [15:0] HDR_CMD       = 16'h30A1;
  localparam logic [15:0] CMD_NULL      = 16'h0000;
  localparam logic [15:0] HDR_GENERAL_1 = 16'h3261;
  localparam logic [15:0] HDR_GENERAL_2 = 16'h3281;
  localparam logic [15:0] HDR_MODE      = 16'h3301;
  localparam logic [15:0] MODE_VALUE    = 16'h3100;
  localparam logic [15:0] CMD_REBOOT    = 16'h000E;
  localparam logic [15:0] NOOP_WORD     = 16'h2000;
  localparam logic [15:0] IDLE_WORD     = 16'hFFFF;

  // ICAP expects the bit order of each byte mirrored relative to the bitstream.
  function automatic logic [15:0] reverse_bits_in_bytes(input logic [15:0] w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[7 - i]  = w[i];
      r[15 - i] = w[8 + i];
    end
    return r;
  endfunction

endpackage

// File: rtl/icap_word_rom.sv
// Combinational lookup of the 16-word IPROG reboot sequence, with the latched
// boot address and SPI read opcode spliced into the GENERAL_1/GENERAL_2 payloads.
module icap_word_rom
  import icap_reboot_ctrl_pkg::*;
#(
  parameter logic [7:0] READ_OPCODE = 8'h6B
) (
  input  logic [3:0]  word_idx,
  input  logic [23:0] boot_addr,
  output logic [15:0] word
);

  always_comb begin
    word = NOOP_WORD;
    case (word_idx)
      4'd0:    word = SYNC_WORD_0;
      4'd1:    word = SYNC_WORD_1;
      4'd2:    word = HDR_CMD;
      4'd3:    word = CMD_NULL;
      4'd4:    word = HDR_GENERAL_1;
      4'd5:    word = boot_addr[15:0];
      4'd6:    word = HDR_GENERAL_2;
      4'd7:    word = {READ_OPCODE, boot_addr[23:16]};
      4'd8:    word = HDR_MODE;
      4'd9:    word = MODE_VALUE;
      4'd10:   word = HDR_CMD;
      4'd11:   word = CMD_REBOOT;
      default: word = NOOP_WORD;
    endcase
  end

endmodule

// File: rtl/icap_reboot_ctrl.sv
// Arbitrates two reboot requesters, waits a guard interval, then streams the
// IPROG sequence into ICAP and parks in HOLD until reset.
module icap_reboot_ctrl
  import icap_reboot_ctrl_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = 16,
  parameter logic [7:0]  READ_OPCODE  = 8'h6B
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [23:0] req_addr0,
  input  logic [23:0] req_addr1,
  output logic [1:0]  ack,
  output logic        busy,
  output logic        icap_ce,
  output logic        icap_wr,
  output logic [15:0] icap_din,
  input  logic        icap_busy
);

  localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  guard_cnt_q, guard_cnt_d;
  logic [3:0]  word_idx_q, word_idx_d;
  logic [23:0] addr_q, addr_d;
  logic [1:0]  ack_q, ack_d;
  logic        icap_ce_q, icap_ce_d;
  logic        icap_wr_q, icap_wr_d;
  logic [15:0] icap_din_q, icap_din_d;
  logic [15:0] rom_word;

  icap_word_rom #(
    .READ_OPCODE(READ_OPCODE)
  ) u_rom (
    .word_idx (word_idx_q),
    .boot_addr(addr_q),
    .word     (rom_word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      guard_cnt_q <= '0;
      word_idx_q  <= '0;
      addr_q      <= '0;
      ack_q       <= '0;
      icap_ce_q   <= 1'b1;
      icap_wr_q   <= 1'b1;
      icap_din_q  <= IDLE_WORD;
    end else begin
      state_q     <= state_d;
      guard_cnt_q <= guard_cnt_d;
      word_idx_q  <= word_idx_d;
      addr_q      <= addr_d;
      ack_q       <= ack_d;
      icap_ce_q   <= icap_ce_d;
      icap_wr_q   <= icap_wr_d;
      icap_din_q  <= icap_din_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    guard_cnt_d = guard_cnt_q;
    word_idx_d  = word_idx_q;
    addr_d      = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          state_d     = ST_GUARD;
          guard_cnt_d = '0;
          word_idx_d  = '0;
          addr_d      = req[0] ? req_addr0 : req_addr1;
        end
      end
      ST_GUARD: begin
        if (guard_cnt_q == GUARD_LAST) begin
          state_d = ST_STREAM;
        end else begin
          guard_cnt_d = guard_cnt_q + 8'd1;
        end
      end
      ST_STREAM: begin
        // The last word leads to HOLD rather than letting the index wrap.
        if (!icap_busy) begin
          if (word_idx_q == LAST_WORD_IDX) begin
            state_d = ST_HOLD;
          end else begin
            word_idx_d = word_idx_q + 4'd1;
          end
        end
      end
      ST_HOLD: state_d = ST_HOLD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_d      = 2'b00;
    icap_ce_d  = 1'b1;
    icap_wr_d  = 1'b1;
    icap_din_d = IDLE_WORD;
    case (state_q)
      ST_IDLE: begin
        if (req[0]) begin
          ack_d = 2'b01;
        end else if (req[1]) begin
          ack_d = 2'b10;
        end
      end
      ST_STREAM: begin
        // A stalled word is repeated with the clock enable deasserted.
        icap_ce_d  = icap_busy;
        icap_wr_d  = 1'b0;
        icap_din_d = reverse_bits_in_bytes(rom_word);
      end
      default: begin
        icap_ce_d = 1'b1;
      end
    endcase
  end

  assign ack      = ack_q;
  assign busy     = (state_q != ST_IDLE);
  assign icap_ce  = icap_ce_q;
  assign icap_wr  = icap_wr_q;
  assign icap_din = icap_din_q;

endmodule

// File: tb/tb_icap_reboot_ctrl.sv
// Scoreboard bench for icap_reboot_ctrl: stimulus pushes the expected ack and
// word stream; a negedge monitor pops and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_icap_reboot_ctrl;

  localparam int         GUARD  = 16;
  localparam logic [7:0] OPCODE = 8'h6B;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [23:0] req_addr0 = '0;
  logic [23:0] req_addr1 = '0;
  logic [1:0]  ack;
  logic        busy;
  logic        icap_ce;
  logic        icap_wr;
  logic [15:0] icap_din;
  logic        icap_busy = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ack_cyc = 0;
  int words_seen = 0;
  bit wait_first = 1'b0;
  logic [15:0] exp_words[$];
  logic [1:0]  exp_acks[$];

  icap_reboot_ctrl #(
    .GUARD_CYCLES(GUARD),
    .READ_OPCODE (OPCODE)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .req_addr0(req_addr0),
    .req_addr1(req_addr1),
    .ack      (ack),
    .busy     (busy),
    .icap_ce  (icap_ce),
    .icap_wr  (icap_wr),
    .icap_din (icap_din),
    .icap_busy(icap_busy)
  );

  always #25 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Mirror each byte arithmetically, one bit at a time.
  function automatic logic [15:0] flip_bytes(input logic [15:0] w);
    int hi = int'(w) / 256;
    int lo = int'(w) % 256;
    int rhi = 0;
    int rlo = 0;
    for (int b = 0; b < 8; b++) begin
      rhi = rhi * 2 + hi % 2;
      hi  = hi / 2;
      rlo = rlo * 2 + lo % 2;
      lo  = lo / 2;
    end
    return 16'(rhi * 256 + rlo);
  endfunction

  function automatic void push_boot(input logic [23:0] a);
    logic [15:0] plain[16];
    int lo16 = int'(a) % 65536;
    int hi8  = int'(a) / 65536;
    plain[0]  = 16'hAA99;
    plain[1]  = 16'h5566;
    plain[2]  = 16'h30A1;
    plain[3]  = 16'h0000;
    plain[4]  = 16'h3261;
    plain[5]  = 16'(lo16);
    plain[6]  = 16'h3281;
    plain[7]  = 16'(32'(OPCODE) * 256 + hi8);
    plain[8]  = 16'h3301;
    plain[9]  = 16'h3100;
    plain[10] = 16'h30A1;
    plain[11] = 16'h000E;
    for (int k = 12; k < 16; k++) plain[k] = 16'h2000;
    for (int k = 0; k < 16; k++) exp_words.push_back(flip_bytes(plain[k]));
  endfunction

  always @(negedge clock) begin
    cyc++;
    if (ack != 2'b00) begin
      if (exp_acks.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected ack: got %0b, expected none", ack);
      end else begin
        checkOutput("ack", 32'(ack), 32'(exp_acks.pop_front()));
      end
      ack_cyc    = cyc;
      wait_first = 1'b1;
    end
    if (icap_ce == 1'b0) begin
      checkOutput("icap_wr with ce", 32'(icap_wr), 32'd0);
      if (wait_first) begin
        checkOutput("guard latency", 32'(cyc - ack_cyc), 32'(GUARD + 1));
        wait_first = 1'b0;
      end
      if (exp_words.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected word: got %0h, expected none", icap_din);
      end else begin
        checkOutput("icap_din", 32'(icap_din), 32'(exp_words.pop_front()));
      end
      words_seen++;
    end
  end

  task automatic doReset();
    reset = 1'b1;
    req = 2'b00;
    icap_busy = 1'b0;
    @(negedge clock); #1;
    reset = 1'b0;
    exp_words.delete();
    exp_acks.delete();
    wait_first = 1'b0;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset ce", 32'(icap_ce), 32'd1);
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [23:0] a0, input logic [23:0] a1,
                               input bit rand_busy, input bit stall_at4, input bit late_req,
                               input bit hold_req, input bit abort_at9);
    int base;
    bit stalled = 1'b0;
    req_addr0 = a0;
    req_addr1 = a1;
    req = r;
    icap_busy = 1'b0;
    exp_acks.push_back(r[0] ? 2'b01 : 2'b10);
    push_boot(r[0] ? a0 : a1);
    base = words_seen;
    for (int n = 0; n < 600 && exp_words.size() > 0; n++) begin
      @(negedge clock); #1;
      if (n >= 1) begin
        req_addr0 = 24'($urandom);
        req_addr1 = 24'($urandom);
        req = hold_req ? r : ((late_req && n >= 4) ? 2'b10 : 2'b00);
      end
      if (abort_at9 && (words_seen - base == 9)) begin
        reset = 1'b1;
        icap_busy = 1'b0;
        @(negedge clock); #1;
        checkOutput("abort ce", 32'(icap_ce), 32'd1);
        checkOutput("abort wr", 32'(icap_wr), 32'd1);
        checkOutput("abort din", 32'(icap_din), 32'hFFFF);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort ack", 32'(ack), 32'd0);
        reset = 1'b0;
        req = 2'b00;
        exp_words.delete();
        exp_acks.delete();
        wait_first = 1'b0;
        return;
      end
      if (stall_at4 && !stalled && (words_seen - base == 4)) begin
        stalled = 1'b1;
        icap_busy = 1'b1;
        repeat (3) begin
          @(negedge clock); #1;
          checkOutput("stall ce", 32'(icap_ce), 32'd1);
          checkOutput("stall din", 32'(icap_din), 32'(flip_bytes(16'h3261)));
        end
        icap_busy = 1'b0;
      end else begin
        icap_busy = (rand_busy && (words_seen - base >= 1)) ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
    end
    checkOutput("words left", 32'(exp_words.size()), 32'd0);
    icap_busy = 1'b0;
    repeat (3) begin
      @(negedge clock); #1;
      checkOutput("hold busy", 32'(busy), 32'd1);
      checkOutput("hold ce", 32'(icap_ce), 32'd1);
      checkOutput("hold wr", 32'(icap_wr), 32'd1);
      checkOutput("hold din", 32'(icap_din), 32'hFFFF);
    end
    req = 2'b00;
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  r;
    logic [23:0] a0, a1;
    bit          hold, late;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset ack", 32'(ack), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset ce", 32'(icap_ce), 32'd1);
    checkOutput("reset wr", 32'(icap_wr), 32'd1);
    checkOutput("reset din", 32'(icap_din), 32'hFFFF);
    reset = 1'b0;

    $display("[TB] single requester 0");
    applyStimulus(2'b01, 24'h0AC000, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    doReset();
    $display("[TB] simultaneous requests");
    applyStimulus(2'b11, 24'h010000, 24'h020000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    doReset();
    $display("[TB] icap_busy stall at GENERAL_1 header");
    applyStimulus(2'b01, 24'h0AC000, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    doReset();
    $display("[TB] reset mid-stream");
    applyStimulus(2'b01, 24'h0AC000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (40) @(negedge clock);
    #1;
    applyStimulus(2'b10, 24'h111111, 24'h3C5A00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    doReset();
    $display("[TB] late requester 1 ignored");
    applyStimulus(2'b01, 24'h0AC000, 24'h777777, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    doReset();
    applyStimulus(2'b01, 24'h000000, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    doReset();
    applyStimulus(2'b10, 24'h000000, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] randomized runs");
    for (int t = 0; t < 20; t++) begin
      doReset();
      r = 2'($urandom_range(1, 3));
      case ($urandom_range(0, 3))
        0:       a0 = 24'h000000;
        1:       a0 = 24'hFFFFFF;
        default: a0 = 24'($urandom);
      endcase
      a1   = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom);
      hold = bit'($urandom_range(0, 1));
      late = !hold && bit'($urandom_range(0, 1));
      applyStimulus(r, a0, a1, 1'b1, 1'b0, late, hold, 1'b0);
    end

    checkOutput("acks left", 32'(exp_acks.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
